sr_ff_bank: RTL and testbench

Parametrised, clocked bank of CH set/reset flip-flops. It replaces our single asynchronous RS latch with a synchronous, glitch-free storage element that also reports illegal inputs. Runtime mode selects conflict resolution (hold, set-dominant, reset-dominant, JK toggle). A saturating counter tallies conflict cycles for the lab display and debug logic.

---
 rtl/sr_pkg.sv | 32 +++
 rtl/sr_ff_cell.sv | 44 ++++
 rtl/sr_ff_bank.sv | 71 +++++++
 tb/tb_sr_ff_bank.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/sr_pkg.sv
// Shared definitions for the set/reset flip-flop bank: mode encodings and
// the single-bit next-state rule used by every channel.
package sr_pkg;

  localparam logic [1:0] MODE_HOLD    = 2'd0;
  localparam logic [1:0] MODE_SET_DOM = 2'd1;
  localparam logic [1:0] MODE_RST_DOM = 2'd2;
  localparam logic [1:0] MODE_JK      = 2'd3;

  // Next state of one bit from S/R only; load and reset priority live in the cell.
  function automatic logic sr_next(input logic q, input logic s, input logic r,
                                   input logic [1:0] mode);
    logic nq;
    nq = q;
    case ({s, r})
      2'b10: nq = 1'b1;
      2'b01: nq = 1'b0;
      2'b11: begin
        case (mode)
          MODE_HOLD:    nq = q;
          MODE_SET_DOM: nq = 1'b1;
          MODE_RST_DOM: nq = 1'b0;
          MODE_JK:      nq = ~q;
          default:      nq = q;
        endcase
      end
      default: nq = q;
    endcase
    return nq;
  endfunction

endpackage

// File: rtl/sr_ff_cell.sv
// One channel of the bank: stored bit, change pulse and conflict flag,
// with reset > load > S/R priority.
module sr_ff_cell
  import sr_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] mode,
  input  logic       s,
  input  logic       r,
  input  logic       ld,
  input  logic       ld_val,
  output logic       q,
  output logic       chg,
  output logic       conflict,
  output logic       conflict_next
);

  logic q_reg;
  logic q_next;
  logic chg_reg;
  logic conflict_reg;

  // A load masks S/R entirely, so it never counts as a conflict.
  assign conflict_next = s & r & ~ld;
  assign q_next        = ld ? ld_val : sr_next(q_reg, s, r, mode);

  always_ff @(posedge clk) begin
    if (rst) begin
      q_reg        <= 1'b0;
      chg_reg      <= 1'b0;
      conflict_reg <= 1'b0;
    end else begin
      q_reg        <= q_next;
      chg_reg      <= (q_next != q_reg);
      conflict_reg <= conflict_next;
    end
  end

  assign q        = q_reg;
  assign chg      = chg_reg;
  assign conflict = conflict_reg;

endmodule

// File: rtl/sr_ff_bank.sv
// Bank of CH synchronous set/reset flip-flops with runtime conflict policy
// and a shared saturating counter of cycles in which any channel conflicted.
module sr_ff_bank
  import sr_pkg::*;
#(
  parameter int CH    = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       mode,
  input  logic [CH-1:0]    S,
  input  logic [CH-1:0]    R,
  input  logic             ld,
  input  logic [CH-1:0]    ld_val,
  input  logic             clr_cnt,
  output logic [CH-1:0]    Q,
  output logic [CH-1:0]    Q_,
  output logic [CH-1:0]    chg,
  output logic [CH-1:0]    conflict,
  output logic [CNT_W-1:0] conflict_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CH-1:0]    conflict_next;
  logic [CNT_W-1:0] cnt_reg;
  logic [CNT_W-1:0] cnt_next;
  logic             any_conflict;

  generate
    for (genvar gi = 0; gi < CH; gi++) begin : g_cell
      sr_ff_cell u_cell (
        .clk           (clk),
        .rst           (rst),
        .mode          (mode),
        .s             (S[gi]),
        .r             (R[gi]),
        .ld            (ld),
        .ld_val        (ld_val[gi]),
        .q             (Q[gi]),
        .chg           (chg[gi]),
        .conflict      (conflict[gi]),
        .conflict_next (conflict_next[gi])
      );
    end
  endgenerate

  assign Q_           = ~Q;
  assign any_conflict = |conflict_next;

  // Clear beats a simultaneous conflict; one step per cycle, no wrap.
  always_comb begin
    cnt_next = cnt_reg;
    if (clr_cnt)
      cnt_next = '0;
    else if (any_conflict && (cnt_reg != CNT_MAX))
      cnt_next = cnt_reg + CNT_ONE;
  end

  always_ff @(posedge clk) begin
    if (rst)
      cnt_reg <= '0;
    else
      cnt_reg <= cnt_next;
  end

  assign conflict_cnt = cnt_reg;

endmodule

// File: tb/tb_sr_ff_bank.sv
// Self-checking bench for sr_ff_bank: directed vector table plus randomized
// traffic against a behavioural model; two instances cover CNT_W=8 and CNT_W=2.
module tb_sr_ff_bank;

  localparam int CH = 4;

  logic       clk;
  logic       rst;
  logic [1:0] mode;
  logic [3:0] s_in, r_in, ld_val;
  logic       ld, clr_cnt;

  logic [3:0] q_a, qn_a, chg_a, conf_a;
  logic [7:0] cnt_a;
  logic [3:0] q_b, qn_b, chg_b, conf_b;
  logic [1:0] cnt_b;

  sr_ff_bank #(.CH(CH), .CNT_W(8)) dut_a (
    .clk(clk), .rst(rst), .mode(mode), .S(s_in), .R(r_in), .ld(ld),
    .ld_val(ld_val), .clr_cnt(clr_cnt), .Q(q_a), .Q_(qn_a), .chg(chg_a),
    .conflict(conf_a), .conflict_cnt(cnt_a)
  );

  sr_ff_bank #(.CH(CH), .CNT_W(2)) dut_b (
    .clk(clk), .rst(rst), .mode(mode), .S(s_in), .R(r_in), .ld(ld),
    .ld_val(ld_val), .clr_cnt(clr_cnt), .Q(q_b), .Q_(qn_b), .chg(chg_b),
    .conflict(conf_b), .conflict_cnt(cnt_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h required %0h", name, got, exp);
  endtask

  // Behavioural reference: per-channel truth table of the spec, counters as ints.
  int m_q[CH], m_chg[CH], m_conf[CH];
  int m_cnt_a = 0, m_cnt_b = 0;

  function automatic logic [3:0] pack(input int v[CH]);
    logic [3:0] p;
    for (int i = 0; i < CH; i++) p[i] = (v[i] != 0);
    return p;
  endfunction

  task automatic model_step();
    int any;
    any = 0;
    if (rst) begin
      for (int i = 0; i < CH; i++) begin m_q[i] = 0; m_chg[i] = 0; m_conf[i] = 0; end
      m_cnt_a = 0;
      m_cnt_b = 0;
      return;
    end
    for (int i = 0; i < CH; i++) begin
      int s, r, nq;
      s  = s_in[i];
      r  = r_in[i];
      nq = m_q[i];
      if (ld)                nq = ld_val[i];
      else if (s == 1 && r == 0) nq = 1;
      else if (s == 0 && r == 1) nq = 0;
      else if (s == 1 && r == 1) begin
        if (mode == 2'd1)      nq = 1;
        else if (mode == 2'd2) nq = 0;
        else if (mode == 2'd3) nq = 1 - m_q[i];
      end
      m_conf[i] = (s == 1 && r == 1 && !ld) ? 1 : 0;
      m_chg[i]  = (nq != m_q[i]) ? 1 : 0;
      m_q[i]    = nq;
      if (m_conf[i] != 0) any = 1;
    end
    if (clr_cnt) begin
      m_cnt_a = 0;
      m_cnt_b = 0;
    end else if (any != 0) begin
      if (m_cnt_a < 255) m_cnt_a++;
      if (m_cnt_b < 3)   m_cnt_b++;
    end
  endtask

  task automatic tick_and_model_check();
    @(posedge clk);
    #1;
    model_step();
    chk("q_a",     {28'd0, q_a},    {28'd0, pack(m_q)});
    chk("qn_a",    {28'd0, qn_a},   {28'd0, ~q_a});
    chk("chg_a",   {28'd0, chg_a},  {28'd0, pack(m_chg)});
    chk("conf_a",  {28'd0, conf_a}, {28'd0, pack(m_conf)});
    chk("cnt_a",   {24'd0, cnt_a},  m_cnt_a);
    chk("q_b",     {28'd0, q_b},    {28'd0, pack(m_q)});
    chk("cnt_b",   {30'd0, cnt_b},  m_cnt_b);
  endtask

  typedef struct {
    logic       rst;
    logic [1:0] mode;
    logic [3:0] s, r;
    logic       ld;
    logic [3:0] ld_val;
    logic       clr;
    logic [3:0] eq, echg, econf;
    logic [7:0] ecnt;
    logic [1:0] ecnt_b;
  } vec_t;

  vec_t vecs[30];

  function automatic vec_t mk(input logic rs, input logic [1:0] md, input logic [3:0] s,
                              input logic [3:0] r, input logic l, input logic [3:0] lv,
                              input logic c, input logic [3:0] eq, input logic [3:0] ec,
                              input logic [3:0] ef, input logic [7:0] en, input logic [1:0] eb);
    vec_t v;
    v.rst = rs; v.mode = md; v.s = s; v.r = r; v.ld = l; v.ld_val = lv; v.clr = c;
    v.eq = eq; v.echg = ec; v.econf = ef; v.ecnt = en; v.ecnt_b = eb;
    return v;
  endfunction

  initial begin
    rst = 1'b1; mode = 2'd0; s_in = '0; r_in = '0; ld = 1'b0; ld_val = '0; clr_cnt = 1'b0;

    //             rst mode  S        R        ld lv       clr  Q        chg      conf     cnt  cnt_b
    vecs[0]  = mk(1, 2'd0, 4'b0000, 4'b0000, 0, 4'b0000, 0, 4'b0000, 4'b0000, 4'b0000, 0, 0);
    vecs[1]  = mk(1, 2'd0, 4'b0000, 4'b0000, 0, 4'b0000, 0, 4'b0000, 4'b0000, 4'b0000, 0, 0);
    vecs[2]  = mk(0, 2'd0, 4'b0101, 4'b0000, 0, 4'b0000, 0, 4'b0101, 4'b0101, 4'b0000, 0, 0);
    vecs[3]  = mk(0, 2'd0, 4'b0000, 4'b0001, 0, 4'b0000, 0, 4'b0100, 4'b0001, 4'b0000, 0, 0);
    vecs[4]  = mk(0, 2'd0, 4'b0001, 4'b0001, 0, 4'b0000, 0, 4'b0100, 4'b0000, 4'b0001, 1, 1);
    vecs[5]  = mk(0, 2'd0, 4'b0001, 4'b0001, 0, 4'b0000, 0, 4'b0100, 4'b0000, 4'b0001, 2, 2);
    vecs[6]  = mk(0, 2'd1, 4'b0001, 4'b0001, 0, 4'b0000, 0, 4'b0101, 4'b0001, 4'b0001, 3, 3);
    vecs[7]  = mk(0, 2'd1, 4'b0001, 4'b0001, 0, 4'b0000, 0, 4'b0101, 4'b0000, 4'b0001, 4, 3);
    vecs[8]  = mk(0, 2'd2, 4'b0001, 4'b0001, 0, 4'b0000, 0, 4'b0100, 4'b0001, 4'b0001, 5, 3);
    vecs[9]  = mk(0, 2'd2, 4'b0001, 4'b0001, 0, 4'b0000, 0, 4'b0100, 4'b0000, 4'b0001, 6, 3);
    vecs[10] = mk(0, 2'd3, 4'b0001, 4'b0001, 0, 4'b0000, 0, 4'b0101, 4'b0001, 4'b0001, 7, 3);
    vecs[11] = mk(0, 2'd3, 4'b0001, 4'b0001, 0, 4'b0000, 0, 4'b0100, 4'b0001, 4'b0001, 8, 3);
    vecs[12] = mk(0, 2'd3, 4'b1111, 4'b1111, 1, 4'b1010, 0, 4'b1010, 4'b1110, 4'b0000, 8, 3);
    vecs[13] = mk(0, 2'd0, 4'b0000, 4'b0000, 0, 4'b0000, 1, 4'b1010, 4'b0000, 4'b0000, 0, 0);
    vecs[14] = mk(0, 2'd0, 4'b0001, 4'b0001, 0, 4'b0000, 0, 4'b1010, 4'b0000, 4'b0001, 1, 1);
    vecs[15] = mk(0, 2'd0, 4'b0001, 4'b0001, 0, 4'b0000, 0, 4'b1010, 4'b0000, 4'b0001, 2, 2);
    vecs[16] = mk(0, 2'd0, 4'b0001, 4'b0001, 0, 4'b0000, 0, 4'b1010, 4'b0000, 4'b0001, 3, 3);
    vecs[17] = mk(0, 2'd0, 4'b0001, 4'b0001, 0, 4'b0000, 0, 4'b1010, 4'b0000, 4'b0001, 4, 3);
    vecs[18] = mk(0, 2'd0, 4'b0001, 4'b0001, 0, 4'b0000, 0, 4'b1010, 4'b0000, 4'b0001, 5, 3);
    vecs[19] = mk(0, 2'd0, 4'b0001, 4'b0001, 0, 4'b0000, 1, 4'b1010, 4'b0000, 4'b0001, 0, 0);
    vecs[20] = mk(0, 2'd0, 4'b0001, 4'b0001, 0, 4'b0000, 0, 4'b1010, 4'b0000, 4'b0001, 1, 1);
    vecs[21] = mk(0, 2'd3, 4'b0000, 4'b0000, 1, 4'b1110, 1, 4'b1110, 4'b0100, 4'b0000, 0, 0);
    vecs[22] = mk(0, 2'd3, 4'b0001, 4'b0001, 0, 4'b0000, 0, 4'b1111, 4'b0001, 4'b0001, 1, 1);
    vecs[23] = mk(0, 2'd3, 4'b0001, 4'b0001, 0, 4'b0000, 0, 4'b1110, 4'b0001, 4'b0001, 2, 2);
    vecs[24] = mk(0, 2'd3, 4'b0001, 4'b0001, 0, 4'b0000, 0, 4'b1111, 4'b0001, 4'b0001, 3, 3);
    vecs[25] = mk(0, 2'd3, 4'b0001, 4'b0001, 0, 4'b0000, 0, 4'b1110, 4'b0001, 4'b0001, 4, 3);
    vecs[26] = mk(0, 2'd3, 4'b0001, 4'b0001, 0, 4'b0000, 0, 4'b1111, 4'b0001, 4'b0001, 5, 3);
    vecs[27] = mk(1, 2'd3, 4'b0001, 4'b0001, 1, 4'b0101, 0, 4'b0000, 4'b0000, 4'b0000, 0, 0);
    vecs[28] = mk(0, 2'd3, 4'b0001, 4'b0001, 0, 4'b0000, 0, 4'b0001, 4'b0001, 4'b0001, 1, 1);
    vecs[29] = mk(0, 2'd0, 4'b0010, 4'b0000, 0, 4'b0000, 0, 4'b0011, 4'b0010, 4'b0000, 1, 1);

    for (int i = 0; i < 30; i++) begin
      rst = vecs[i].rst; mode = vecs[i].mode; s_in = vecs[i].s; r_in = vecs[i].r;
      ld = vecs[i].ld; ld_val = vecs[i].ld_val; clr_cnt = vecs[i].clr;
      tick_and_model_check();
      chk($sformatf("vec%0d_q", i),     {28'd0, q_a},    {28'd0, vecs[i].eq});
      chk($sformatf("vec%0d_qn", i),    {28'd0, qn_a},   {28'd0, ~vecs[i].eq});
      chk($sformatf("vec%0d_chg", i),   {28'd0, chg_a},  {28'd0, vecs[i].echg});
      chk($sformatf("vec%0d_conf", i),  {28'd0, conf_a}, {28'd0, vecs[i].econf});
      chk($sformatf("vec%0d_cnt", i),   {24'd0, cnt_a},  {24'd0, vecs[i].ecnt});
      chk($sformatf("vec%0d_cnt_b", i), {30'd0, cnt_b},  {30'd0, vecs[i].ecnt_b});
      $display("vec %0d: rst=%b mode=%0d S=%b R=%b ld=%b -> Q=%b chg=%b conf=%b cnt=%0d cnt_b=%0d",
               i, rst, mode, s_in, r_in, ld, q_a, chg_a, conf_a, cnt_a, cnt_b);
    end

    for (int c = 0; c < 10000; c++) begin
      rst     = ($urandom_range(0, 63) == 0);
      mode    = 2'($urandom_range(0, 3));
      s_in    = 4'($urandom);
      r_in    = 4'($urandom);
      ld      = ($urandom_range(0, 7) == 0);
      ld_val  = 4'($urandom);
      clr_cnt = ($urandom_range(0, 15) == 0);
      tick_and_model_check();
      if ((c % 1000) == 999)
        $display("random block ending at cycle %0d: Q=%b cnt=%0d cnt_b=%0d", c, q_a, cnt_a, cnt_b);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
